// File: rtl/tone_i2s_driver.sv
// tone_i2s_driver: converts stereo tone words (Hz) into +/-AMP square-wave
// samples and serializes them to a Pmod I2S DAC in left-justified format.
// Optional build macro: VOLUME_EN adds a 3-bit volume input.
module tone_i2s_driver #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned SIL_THRESH = 20000,
    parameter logic [15:0] AMP        = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] toneL,
    input  logic [31:0] toneR,
`ifdef VOLUME_EN
    input  logic [2:0]  volume,
`endif
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, DIV_L, DIV_R} state_t;

    state_t      r_state;
    logic [8:0]  r_fc;
    logic        r_busy, r_force, r_sdin;
    logic [31:0] r_lastL, r_lastR, r_halfL, r_halfR;
    logic [32:0] r_rem, r_div;
    logic [31:0] r_quo;
    logic [5:0]  r_cnt;
    logic [31:0] r_phL, r_phR;
    logic        r_polL, r_polR;
    logic [15:0] r_shL, r_shR;

    logic [33:0] w_rem_sh;
    logic        w_ge;
    logic [32:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic        w_silL, w_silR;
    logic [15:0] w_amp, w_smpL, w_smpR, w_srcL, w_srcR;
    logic [8:0]  w_fc_nx;

    // one restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_rem_sh = {r_rem, r_quo[31]};
        w_ge     = (w_rem_sh >= {1'b0, r_div});
        w_rem_nx = w_ge ? 33'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[32:0];
        w_quo_nx = {r_quo[30:0], w_ge};
        w_silL   = (r_lastL == 32'd0) || (r_lastL >= SIL_THRESH);
        w_silR   = (r_lastR == 32'd0) || (r_lastR >= SIL_THRESH);
    end

    // sample generation with optional volume scaling
    always_comb begin
`ifdef VOLUME_EN
        w_amp = (volume == 3'd0) ? '0 : (AMP >> (3'd7 - volume));
`else
        w_amp = AMP;
`endif
        w_smpL  = (r_halfL == 32'd0) ? '0 : (r_polL ? w_amp : -w_amp);
        w_smpR  = (r_halfR == 32'd0) ? '0 : (r_polR ? w_amp : -w_amp);
        w_fc_nx = r_fc + 9'd1;
        // at the frame boundary the shadows are loading this very edge, so bypass them
        w_srcL  = (r_fc == 9'd511) ? w_smpL : r_shL;
        w_srcR  = (r_fc == 9'd511) ? w_smpR : r_shR;
    end

    // divider FSM: recompute both half-periods whenever a tone changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_force <= 1'b1;
            r_lastL <= '0;
            r_lastR <= '0;
            r_halfL <= '0;
            r_halfR <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_force || (toneL != r_lastL) || (toneR != r_lastR)) begin
                        r_lastL <= toneL;
                        r_lastR <= toneR;
                        r_force <= 1'b0;
                        r_rem   <= '0;
                        r_quo   <= 32'(CLK_HZ);
                        r_div   <= {toneL, 1'b0};
                        r_cnt   <= '0;
                        r_state <= DIV_L;
                        r_busy  <= 1'b1;
                    end
                end
                DIV_L: begin
                    if (w_silL || r_cnt == 6'd32) begin
                        r_halfL <= w_silL ? '0 : r_quo;
                        r_rem   <= '0;
                        r_quo   <= 32'(CLK_HZ);
                        r_div   <= {r_lastR, 1'b0};
                        r_cnt   <= '0;
                        r_state <= DIV_R;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                DIV_R: begin
                    if (w_silR || r_cnt == 6'd32) begin
                        r_halfR <= w_silR ? '0 : r_quo;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // square-wave phase counters; >= compare lets a shrinking half-period apply at once
    always_ff @(posedge clk) begin
        if (rst || r_halfL == 32'd0) begin
            r_phL  <= '0;
            r_polL <= 1'b0;
        end else if (({1'b0, r_phL} + 33'd1) >= {1'b0, r_halfL}) begin
            r_phL  <= '0;
            r_polL <= ~r_polL;
        end else begin
            r_phL <= r_phL + 32'd1;
        end
        if (rst || r_halfR == 32'd0) begin
            r_phR  <= '0;
            r_polR <= 1'b0;
        end else if (({1'b0, r_phR} + 33'd1) >= {1'b0, r_halfR}) begin
            r_phR  <= '0;
            r_polR <= ~r_polR;
        end else begin
            r_phR <= r_phR + 32'd1;
        end
    end

    // frame counter, shadow capture and serial data launch on the sck falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fc   <= '0;
            r_shL  <= '0;
            r_shR  <= '0;
            r_sdin <= 1'b0;
        end else begin
            r_fc <= w_fc_nx;
            if (r_fc == 9'd511) begin
                r_shL <= w_smpL;
                r_shR <= w_smpR;
            end
            if (r_fc[3:0] == 4'd15)
                r_sdin <= w_fc_nx[8] ? w_srcR[~w_fc_nx[7:4]] : w_srcL[~w_fc_nx[7:4]];
        end
    end

    assign audio_mclk = r_fc[1];
    assign audio_sck  = r_fc[3];
    assign audio_lrck = r_fc[8];
    assign audio_sdin = r_sdin;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tone_i2s_driver.sv
// Directed self-checking bench for tone_i2s_driver (deserializes sdin).
module tb_tone_i2s_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] toneL, toneR;
`ifdef VOLUME_EN
    logic [2:0]  volume;
`endif
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, busy;

    int n_chk = 0;
    int n_err = 0;

    tone_i2s_driver dut (
        .clk        (clk),
        .rst        (rst),
        .toneL      (toneL),
        .toneR      (toneR),
`ifdef VOLUME_EN
        .volume     (volume),
`endif
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference frame counter
    logic [8:0] tb_fc;
    always @(posedge clk) begin
        if (rst) tb_fc <= '0;
        else     tb_fc <= tb_fc + 9'd1;
    end

    // deserializer: sample mid-bit (sck high), words complete on last slot
    logic [15:0] acc, wordL, wordR;
    int          cntL = 0;
    logic        prev_sdin = 1'b0;
    logic        clk_chk_en = 1'b0;
    always @(negedge clk) begin
        if (!rst && tb_fc[3:0] == 4'd8) begin
            acc <= {acc[14:0], audio_sdin};
            if (tb_fc == 9'd248) begin
                wordL <= {acc[14:0], audio_sdin};
                cntL  <= cntL + 1;
            end
            if (tb_fc == 9'd504) wordR <= {acc[14:0], audio_sdin};
        end
        if (clk_chk_en) begin
            chk("mclk", {31'd0, audio_mclk}, {31'd0, tb_fc[1]});
            chk("sck",  {31'd0, audio_sck},  {31'd0, tb_fc[3]});
            chk("lrck", {31'd0, audio_lrck}, {31'd0, tb_fc[8]});
            if (audio_sdin != prev_sdin) chk("sdin_edge", {28'd0, tb_fc[3:0]}, 32'd0);
        end
        prev_sdin <= audio_sdin;
    end

    task automatic count_busy(input int ncyc, output int c);
        c = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (busy) c++;
        end
    endtask

    task automatic wait_words(input int n);
        int start, lim;
        start = cntL;
        lim   = 0;
        while (cntL < start + n && lim < n * 512 + 600) begin
            @(negedge clk);
            lim++;
        end
        chk("word_timeout", {31'd0, cntL >= start + n}, 32'd1);
        @(negedge clk); // let wordR of the same frame settle
        repeat (260) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl);
        int lim;
        lim = 0;
        while (busy !== lvl && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        chk("busy_wait", {31'd0, busy}, {31'd0, lvl});
    endtask

    int  c;
    int  changes;
    logic [15:0] prevw;
    logic sawp, sawn;

    initial begin
        rst = 1'b1; toneL = 32'd440; toneR = 32'd440;
`ifdef VOLUME_EN
        volume = 3'd7;
`endif
        repeat (3) @(negedge clk);
        chk("rst_mclk", {31'd0, audio_mclk}, 32'd0);
        chk("rst_sck",  {31'd0, audio_sck},  32'd0);
        chk("rst_lrck", {31'd0, audio_lrck}, 32'd0);
        chk("rst_sdin", {31'd0, audio_sdin}, 32'd0);
        chk("rst_busy", {31'd0, busy},       32'd0);
        chk("rst_halfL", dut.r_halfL, 32'd0);

        // 440/440 after reset: force flag recomputes both channels
        rst = 1'b0;
        clk_chk_en = 1'b1;
        count_busy(150, c);
        chk("busy_440", c, 32'd66);
        chk("halfL_440", dut.r_halfL, 32'd113636);
        chk("halfR_440", dut.r_halfR, 32'd113636);
        wait_words(3);
        clk_chk_en = 1'b0;
        chk("wordL_440", {16'd0, wordL}, 32'h0000E000);
        chk("wordR_440", {16'd0, wordR}, 32'h0000E000);

        // just below threshold: fast toggling, words alternate between +/-AMP
        toneL = 32'd19999;
        count_busy(100, c);
        chk("busy_19999", c, 32'd66);
        chk("halfL_19999", dut.r_halfL, 32'd2500);
        changes = 0; sawp = 1'b0; sawn = 1'b0; prevw = 16'hE000;
        for (int i = 0; i < 12; i++) begin
            wait_words(1);
            chk("wordL_pm", {31'd0, (wordL == 16'h2000) || (wordL == 16'hE000)}, 32'd1);
            if (wordL == 16'h2000) sawp = 1'b1;
            if (wordL == 16'hE000) sawn = 1'b1;
            if (wordL != prevw) changes++;
            prevw = wordL;
        end
        chk("wordL_both", {30'd0, sawp, sawn}, 32'd3);
        chk("wordL_toggled", {31'd0, changes >= 2}, 32'd1);

        // silence code on left, 262 Hz on right
        toneL = 32'd50000000; toneR = 32'd262;
        count_busy(100, c);
        chk("busy_sil", c, 32'd34);
        chk("halfL_sil", dut.r_halfL, 32'd0);
        chk("halfR_262", dut.r_halfR, 32'd190839);
        wait_words(3);
        chk("wordL_sil", {16'd0, wordL}, 32'd0);
        chk("wordR_262", {31'd0, (wordR == 16'h2000) || (wordR == 16'hE000)}, 32'd1);

        // exact threshold and zero are both silent
        toneL = 32'd20000; toneR = 32'd0;
        count_busy(100, c);
        chk("busy_thr", c, 32'd2);
        chk("halfL_thr", dut.r_halfL, 32'd0);
        chk("halfR_zero", dut.r_halfR, 32'd0);
        wait_words(3);
        chk("wordL_thr", {16'd0, wordL}, 32'd0);
        chk("wordR_zero", {16'd0, wordR}, 32'd0);

        // change left tone while the right channel is dividing
        toneL = 32'd440; toneR = 32'd440;
        clk_chk_en = 1'b1;
        wait_busy(1'b1);
        repeat (40) @(negedge clk);
        toneL = 32'd880;
        wait_busy(1'b0);
        count_busy(100, c);
        chk("busy_redo", c, 32'd66);
        chk("halfL_880", dut.r_halfL, 32'd56818);
        chk("halfR_redo", dut.r_halfR, 32'd113636);
        clk_chk_en = 1'b0;

        // reset in the middle of a division near fc = 300
        c = 0;
        while (tb_fc != 9'd295 && c < 600) begin
            @(negedge clk);
            c++;
        end
        toneL = 32'd262;
        wait_busy(1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_clks", {29'd0, audio_mclk, audio_sck, audio_lrck}, 32'd0);
        chk("mrst_sdin", {31'd0, audio_sdin}, 32'd0);
        chk("mrst_halfL", dut.r_halfL, 32'd0);
        chk("mrst_halfR", dut.r_halfR, 32'd0);
        rst = 1'b0;
        count_busy(100, c);
        chk("busy_force", c, 32'd66);
        chk("halfL_force", dut.r_halfL, 32'd190839);
        chk("halfR_force", dut.r_halfR, 32'd113636);

`ifdef VOLUME_EN
        volume = 3'd4;
        wait_words(3);
        chk("vol4", {31'd0, (wordL == 16'h0400) || (wordL == 16'hFC00)}, 32'd1);
        volume = 3'd0;
        wait_words(3);
        chk("vol0", {16'd0, wordL}, 32'd0);
        volume = 3'd7;
        wait_words(3);
        chk("vol7", {31'd0, (wordL == 16'h2000) || (wordL == 16'hE000)}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
